// File: rtl/strobe_sync_pkg.sv
// strobe_sync_pkg: shared types and limits for the toggle-strobe bus synchronizer
package strobe_sync_pkg;
  typedef enum logic {ACK_ON_CONSUME, ACK_ON_CAPTURE} ack_mode_e;
  localparam int MIN_SYNC_STAGES = 2;
endpackage

// File: rtl/strobe_sync_ff_chain.sv
// strobe_sync_ff_chain: single-bit async-reset synchronizer flop chain
module strobe_sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] stg_q, stg_d;
  always_comb stg_d = {stg_q[STAGES-2:0], d};
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) stg_q <= '0;
    else stg_q <= stg_d;
  assign q = stg_q[STAGES-1];
endmodule

// File: rtl/strobe_sync_rx_multi.sv
// strobe_sync_rx_multi: receive half of a multi-channel toggle-strobe bus synchronizer
module strobe_sync_rx_multi
  import strobe_sync_pkg::*;
#(
  parameter int        WIDTH       = 4,
  parameter int        CHANNELS    = 2,
  parameter int        SYNC_STAGES = 2,
  parameter ack_mode_e ACK_MODE    = ACK_ON_CONSUME
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic [CHANNELS-1:0]       req_tgl_in,
  input  logic [CHANNELS*WIDTH-1:0] bus_in,
  output logic [CHANNELS-1:0]       ack_tgl_out,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] synchronized_bus,
  output logic [CHANNELS-1:0]       overrun,
  input  logic [CHANNELS-1:0]       clear_overrun
);
  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] ARM_LOAD = CW'(SYNC_STAGES + 1);
  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be >= 1");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("SYNC_STAGES must be >= 2");
  end
  logic [CHANNELS-1:0] sync_out, strobe, consume, capture, drop;
  logic [CHANNELS-1:0] req_seen_q, req_seen_d, ack_q, ack_d, valid_q, valid_d, ovr_q, ovr_d;
  logic [CHANNELS*WIDTH-1:0] bus_q, bus_d;
  logic [CW-1:0] arm_q, arm_d;
  logic arming;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    strobe_sync_ff_chain #(.STAGES(SYNC_STAGES)) u_chain (
      .clk (clk),
      .rstb(rstb),
      .d   (req_tgl_in[i]),
      .q   (sync_out[i])
    );
  end
  // while arming, ack and req_seen track the synchronized req so a held-high source re-aligns
  always_comb begin
    arming     = arm_q != '0;
    arm_d      = arming ? arm_q - 1'b1 : arm_q;
    strobe     = sync_out ^ req_seen_q;
    consume    = valid_q & out_ready;
    capture    = arming ? '0 : strobe & (~valid_q | consume);
    drop       = arming ? '0 : strobe & valid_q & ~consume;
    req_seen_d = sync_out;
    valid_d    = capture | (valid_q & ~consume);
    ovr_d      = drop | (ovr_q & ~clear_overrun);
    ack_d      = arming ? sync_out : ack_q ^ (ACK_MODE == ACK_ON_CAPTURE ? strobe : consume);
    bus_d      = bus_q;
    for (int c = 0; c < CHANNELS; c++)
      bus_d[c*WIDTH +: WIDTH] = capture[c] ? bus_in[c*WIDTH +: WIDTH] : bus_q[c*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      arm_q      <= ARM_LOAD;
      req_seen_q <= '0;
      ack_q      <= '0;
      valid_q    <= '0;
      ovr_q      <= '0;
      bus_q      <= '0;
    end else begin
      arm_q      <= arm_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      bus_q      <= bus_d;
    end
  assign ack_tgl_out      = ack_q;
  assign out_valid        = valid_q;
  assign synchronized_bus = bus_q;
  assign overrun          = ovr_q;
endmodule

// File: tb/tb_strobe_sync_rx_multi.sv
// tb_strobe_sync_rx_multi: vector-table bench driving one DUT per ack mode from shared stimulus
module tb_strobe_sync_rx_multi;
  import strobe_sync_pkg::*;
  logic clk = 1'b0, rstb;
  logic [1:0] req, rdy, clr;
  logic [7:0] bus;
  logic [1:0] ack_c, valid_c, ovr_c, ack_p, valid_p, ovr_p;
  logic [7:0] sbus_c, sbus_p;
  int checks = 0, failures = 0;
  typedef struct {
    logic [1:0] req;
    logic [7:0] bus;
    logic [1:0] rdy, clr, valid;
    logic [7:0] sbus;
    logic [1:0] ack_c, ack_p, ovr;
  } vec_t;
  vec_t vq[$];
  always #5 clk = ~clk;
  strobe_sync_rx_multi #(.ACK_MODE(ACK_ON_CONSUME)) u_c (
    .clk(clk), .rstb(rstb), .req_tgl_in(req), .bus_in(bus), .ack_tgl_out(ack_c),
    .out_valid(valid_c), .out_ready(rdy), .synchronized_bus(sbus_c), .overrun(ovr_c),
    .clear_overrun(clr)
  );
  strobe_sync_rx_multi #(.ACK_MODE(ACK_ON_CAPTURE)) u_p (
    .clk(clk), .rstb(rstb), .req_tgl_in(req), .bus_in(bus), .ack_tgl_out(ack_p),
    .out_valid(valid_p), .out_ready(rdy), .synchronized_bus(sbus_p), .overrun(ovr_p),
    .clear_overrun(clr)
  );
  task automatic chk2(input string n, input logic [1:0] a, input logic [1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", n, a, e);
    end
  endtask
  task automatic chk8(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  task automatic chk_zero(input string n);
    chk2({n, "_valid_c"}, valid_c, 2'b00);
    chk2({n, "_valid_p"}, valid_p, 2'b00);
    chk8({n, "_sbus_c"}, sbus_c, 8'h00);
    chk8({n, "_sbus_p"}, sbus_p, 8'h00);
    chk2({n, "_ack_c"}, ack_c, 2'b00);
    chk2({n, "_ack_p"}, ack_p, 2'b00);
    chk2({n, "_ovr_c"}, ovr_c, 2'b00);
    chk2({n, "_ovr_p"}, ovr_p, 2'b00);
  endtask
  task automatic add(input logic [1:0] r, input logic [7:0] b, input logic [1:0] rd, cl, v,
                     input logic [7:0] sb, input logic [1:0] ac, ap, ov);
    vq.push_back('{req: r, bus: b, rdy: rd, clr: cl, valid: v, sbus: sb, ack_c: ac, ack_p: ap, ovr: ov});
  endtask
  initial begin
    add(2'b01, 8'h0A, 2'b00, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 8'h0A, 2'b00, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 8'h0A, 2'b00, 2'b00, 2'b01, 8'h0A, 2'b00, 2'b01, 2'b00);
    add(2'b01, 8'h0A, 2'b01, 2'b00, 2'b00, 8'h0A, 2'b01, 2'b01, 2'b00);
    add(2'b11, 8'h3A, 2'b00, 2'b00, 2'b00, 8'h0A, 2'b01, 2'b01, 2'b00);
    add(2'b11, 8'h3A, 2'b00, 2'b00, 2'b00, 8'h0A, 2'b01, 2'b01, 2'b00);
    add(2'b11, 8'h3A, 2'b00, 2'b00, 2'b10, 8'h3A, 2'b01, 2'b11, 2'b00);
    add(2'b01, 8'h7A, 2'b00, 2'b00, 2'b10, 8'h3A, 2'b01, 2'b11, 2'b00);
    add(2'b01, 8'h7A, 2'b00, 2'b00, 2'b10, 8'h3A, 2'b01, 2'b11, 2'b00);
    add(2'b01, 8'h7A, 2'b00, 2'b00, 2'b10, 8'h3A, 2'b01, 2'b01, 2'b10);
    add(2'b01, 8'h7A, 2'b00, 2'b10, 2'b10, 8'h3A, 2'b01, 2'b01, 2'b00);
    add(2'b01, 8'h7A, 2'b10, 2'b00, 2'b00, 8'h3A, 2'b11, 2'b01, 2'b00);
    add(2'b00, 8'h05, 2'b00, 2'b00, 2'b00, 8'h3A, 2'b11, 2'b01, 2'b00);
    add(2'b00, 8'h05, 2'b00, 2'b00, 2'b00, 8'h3A, 2'b11, 2'b01, 2'b00);
    add(2'b00, 8'h05, 2'b00, 2'b00, 2'b01, 8'h35, 2'b11, 2'b00, 2'b00);
    add(2'b01, 8'h0C, 2'b00, 2'b00, 2'b01, 8'h35, 2'b11, 2'b00, 2'b00);
    add(2'b01, 8'h0C, 2'b00, 2'b00, 2'b01, 8'h35, 2'b11, 2'b00, 2'b00);
    add(2'b01, 8'h0C, 2'b01, 2'b00, 2'b01, 8'h3C, 2'b10, 2'b01, 2'b00);
    add(2'b01, 8'h0C, 2'b00, 2'b00, 2'b01, 8'h3C, 2'b10, 2'b01, 2'b00);
    add(2'b01, 8'h0C, 2'b01, 2'b00, 2'b00, 8'h3C, 2'b11, 2'b01, 2'b00);
    add(2'b10, 8'h9E, 2'b00, 2'b00, 2'b00, 8'h3C, 2'b11, 2'b01, 2'b00);
    add(2'b10, 8'h9E, 2'b00, 2'b00, 2'b00, 8'h3C, 2'b11, 2'b01, 2'b00);
    add(2'b10, 8'h9E, 2'b00, 2'b00, 2'b11, 8'h9E, 2'b11, 2'b10, 2'b00);
    add(2'b10, 8'h9E, 2'b10, 2'b00, 2'b01, 8'h9E, 2'b01, 2'b10, 2'b00);
    add(2'b10, 8'h9E, 2'b01, 2'b00, 2'b00, 8'h9E, 2'b00, 2'b10, 2'b00);
    add(2'b11, 8'h91, 2'b00, 2'b00, 2'b00, 8'h9E, 2'b00, 2'b10, 2'b00);
    add(2'b11, 8'h91, 2'b00, 2'b00, 2'b00, 8'h9E, 2'b00, 2'b10, 2'b00);
    add(2'b11, 8'h91, 2'b00, 2'b00, 2'b01, 8'h91, 2'b00, 2'b11, 2'b00);
    add(2'b10, 8'h92, 2'b00, 2'b00, 2'b01, 8'h91, 2'b00, 2'b11, 2'b00);
    add(2'b10, 8'h92, 2'b00, 2'b00, 2'b01, 8'h91, 2'b00, 2'b11, 2'b00);
    add(2'b10, 8'h92, 2'b00, 2'b01, 2'b01, 8'h91, 2'b00, 2'b10, 2'b01);
    add(2'b10, 8'h92, 2'b00, 2'b01, 2'b01, 8'h91, 2'b00, 2'b10, 2'b00);
    rstb = 1'b0; req = '0; bus = '0; rdy = '0; clr = '0;
    #1 chk_zero("por");
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (5) @(posedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      req = vq[i].req; bus = vq[i].bus; rdy = vq[i].rdy; clr = vq[i].clr;
      @(posedge clk);
      #1;
      chk2($sformatf("v%0d_valid_c", i), valid_c, vq[i].valid);
      chk2($sformatf("v%0d_valid_p", i), valid_p, vq[i].valid);
      chk8($sformatf("v%0d_sbus_c", i), sbus_c, vq[i].sbus);
      chk8($sformatf("v%0d_sbus_p", i), sbus_p, vq[i].sbus);
      chk2($sformatf("v%0d_ack_c", i), ack_c, vq[i].ack_c);
      chk2($sformatf("v%0d_ack_p", i), ack_p, vq[i].ack_p);
      chk2($sformatf("v%0d_ovr_c", i), ovr_c, vq[i].ovr);
      chk2($sformatf("v%0d_ovr_p", i), ovr_p, vq[i].ovr);
    end
    @(negedge clk);
    rdy = '0; clr = '0; rstb = 1'b0; req = 2'b11;
    #1 chk_zero("arm_rst");
    @(negedge clk);
    rstb = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk2($sformatf("arm%0d_valid_c", k), valid_c, 2'b00);
      chk2($sformatf("arm%0d_valid_p", k), valid_p, 2'b00);
      chk2($sformatf("arm%0d_ack_c", k), ack_c, k == 3 ? 2'b11 : 2'b00);
      chk2($sformatf("arm%0d_ack_p", k), ack_p, k == 3 ? 2'b11 : 2'b00);
    end
    repeat (4) begin
      @(posedge clk);
      #1;
      chk2("post_arm_valid_c", valid_c, 2'b00);
      chk2("post_arm_valid_p", valid_p, 2'b00);
      chk2("post_arm_ovr_p", ovr_p, 2'b00);
      chk2("post_arm_ack_c", ack_c, 2'b11);
      chk2("post_arm_ack_p", ack_p, 2'b11);
    end
    @(negedge clk);
    req = 2'b10; bus = 8'h0F;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b0;
    #1 chk_zero("mid_rst");
    @(negedge clk);
    rstb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk2("rearm_ack_c", ack_c, 2'b10);
    chk2("rearm_ack_p", ack_p, 2'b10);
    repeat (4) begin
      @(posedge clk);
      #1;
      chk2("rearm_valid_c", valid_c, 2'b00);
      chk2("rearm_valid_p", valid_p, 2'b00);
      chk8("rearm_sbus_p", sbus_p, 8'h00);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
